// File: rtl/sipo_framed_pkg.sv
// sipo_framed_pkg -- shared definitions for the framed serial deserializer.
//   * Receiver FSM state encodings (localparams) and the enum built on them.
//   * Default clk cycles per serial bit used by the receiver and its benches.
package sipo_framed_pkg;

    localparam int SIPO_DEFAULT_CPB = 16;

    localparam logic [2:0] ENC_IDLE      = 3'd0;
    localparam logic [2:0] ENC_START     = 3'd1;
    localparam logic [2:0] ENC_DATA      = 3'd2;
    localparam logic [2:0] ENC_PARITY    = 3'd3;
    localparam logic [2:0] ENC_STOP      = 3'd4;
    localparam logic [2:0] ENC_WAIT_HIGH = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = ENC_IDLE,
        ST_START     = ENC_START,
        ST_DATA      = ENC_DATA,
        ST_PARITY    = ENC_PARITY,
        ST_STOP      = ENC_STOP,
        ST_WAIT_HIGH = ENC_WAIT_HIGH
    } sipo_state_e;

endpackage

// File: rtl/sipo_framed_bit_sync.sv
// bit_sync -- two-flop synchronizer for a single asynchronous input bit.
// Ports:
//   clk   : sampling clock
//   reset : asynchronous, active-high; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output (two clk edges of latency)
module bit_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_p0 <= RESET_VAL;
            q       <= RESET_VAL;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/sipo_framed.sv
// sipo_framed -- framed serial-in, parallel-out receiver.
// Frame: start bit (low), DATA_W data bits, optional parity bit, stop bit (high).
// Ports:
//   clk          : single rising-edge clock
//   reset        : asynchronous, active-high
//   i_serial     : serial line, idles high, asynchronous to clk
//   o_data       : received word, stable while o_valid is high
//   o_valid      : o_data holds an unconsumed word
//   i_ready      : consumer takes the word when o_valid && i_ready
//   o_parity_err : parity mismatch for the held word (qualified by o_valid)
//   o_frame_err  : one-cycle pulse, stop bit sampled low
//   o_overrun    : one-cycle pulse, good frame dropped because output was full
//   o_busy       : receiver FSM is not idle
module sipo_framed
    import sipo_framed_pkg::*;
#(
    parameter int DATA_W         = 7,
    parameter int CYCLES_PER_BIT = SIPO_DEFAULT_CPB,
    parameter bit LSB_FIRST      = 1'b1,
    parameter bit PARITY_EN      = 1'b0,
    parameter bit PARITY_ODD     = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_serial,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_overrun,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(CYCLES_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    // Insert one received bit; LSB-first fills from the top so the first
    // bit ends up in [0], MSB-first fills from the bottom.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] word,
                                                   input logic              b);
        logic [DATA_W-1:0] b_ext;
        b_ext = DATA_W'(b);
        if (LSB_FIRST)
            return (word >> 1) | (b_ext << (DATA_W - 1));
        else
            return (word << 1) | b_ext;
    endfunction

    function automatic logic parity_mismatch(input logic [DATA_W-1:0] word,
                                             input logic              pbit);
        return ((^word) ^ pbit) != PARITY_ODD;
    endfunction

    logic              s;
    sipo_state_e       state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [IDX_W-1:0]  idx, idx_next;
    logic              shift_en;
    logic              par_sample;
    logic              stop_sample;
    logic [DATA_W-1:0] shreg;
    logic              perr_pend;
    logic              good_p0;
    logic              bad_p0;

    // Stage: line synchronisation into s
    bit_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (i_serial),
        .q     (s)
    );

    always_comb begin
        state_next  = state;
        cnt_next    = cnt + 1'b1;
        idx_next    = idx;
        shift_en    = 1'b0;
        par_sample  = 1'b0;
        stop_sample = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (!s) state_next = ST_START;
            end
            ST_START: begin
                // Mid-start-bit check: a line that is high again was a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    shift_en = 1'b1;
                    idx_next = idx + 1'b1;
                    if (idx == IDX_LAST)
                        state_next = PARITY_EN ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    par_sample = 1'b1;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next    = '0;
                    stop_sample = 1'b1;
                    state_next  = s ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                // A break (held-low line) must not look like a new start bit.
                cnt_next = '0;
                if (s) state_next = ST_IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Stage: FSM sampling, p0 frame-complete flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            perr_pend <= 1'b0;
            good_p0   <= 1'b0;
            bad_p0    <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            idx     <= idx_next;
            good_p0 <= stop_sample && s;
            bad_p0  <= stop_sample && !s;
            if (par_sample)
                perr_pend <= parity_mismatch(shreg, s);
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en)
            shreg <= shift_in(shreg, s);
    end

    // Stage: output register and handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_frame_err <= bad_p0;
            o_overrun   <= 1'b0;
            if (good_p0 && (!o_valid || i_ready)) begin
                // A word accepted on this same edge frees the slot for the new one.
                o_data       <= shreg;
                o_parity_err <= perr_pend;
                o_valid      <= 1'b1;
            end else begin
                if (good_p0)
                    o_overrun <= 1'b1;
                if (o_valid && i_ready)
                    o_valid <= 1'b0;
            end
        end
    end

    assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sipo_framed.sv
// tb_sipo_framed -- directed bench for sipo_framed.
// Three instances: A (C=8, W=7, LSB first, no parity), P (same with even
// parity) and M (C=4, W=16, MSB first). Serial frames are driven on the
// falling edge; outputs are observed on the falling edge.
module tb_sipo_framed;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ser_a = 1'b1, ser_p = 1'b1, ser_m = 1'b1;
    logic        ready_a = 1'b1, ready_p = 1'b1, ready_m = 1'b1;
    logic [6:0]  data_a, data_p;
    logic [15:0] data_m;
    logic        valid_a, valid_p, valid_m;
    logic        perr_a, perr_p, perr_m;
    logic        ferr_a, ferr_p, ferr_m;
    logic        ovr_a, ovr_p, ovr_m;
    logic        busy_a, busy_p, busy_m;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Observers for instance A
    logic       valid_a_q = 1'b0;
    int         rise_cnt_a = 0, rise_cyc_a = 0, vhi_cnt_a = 0, ferr_cnt_a = 0, ovr_cnt_a = 0;
    logic [6:0] rise_data_a = '0;
    logic       rise_perr_a = 1'b0;
    // Observers for instances P and M
    logic        valid_p_q = 1'b0, valid_m_q = 1'b0;
    int          rise_cnt_p = 0, rise_cnt_m = 0;
    logic [6:0]  rise_data_p = '0;
    logic        rise_perr_p = 1'b0;
    logic [15:0] rise_data_m = '0;

    always #5 clk = ~clk;

    sipo_framed #(.DATA_W(7), .CYCLES_PER_BIT(8), .LSB_FIRST(1'b1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_a (
        .clk(clk), .reset(reset), .i_serial(ser_a), .o_data(data_a), .o_valid(valid_a),
        .i_ready(ready_a), .o_parity_err(perr_a), .o_frame_err(ferr_a), .o_overrun(ovr_a), .o_busy(busy_a));

    sipo_framed #(.DATA_W(7), .CYCLES_PER_BIT(8), .LSB_FIRST(1'b1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_p (
        .clk(clk), .reset(reset), .i_serial(ser_p), .o_data(data_p), .o_valid(valid_p),
        .i_ready(ready_p), .o_parity_err(perr_p), .o_frame_err(ferr_p), .o_overrun(ovr_p), .o_busy(busy_p));

    sipo_framed #(.DATA_W(16), .CYCLES_PER_BIT(4), .LSB_FIRST(1'b0), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_m (
        .clk(clk), .reset(reset), .i_serial(ser_m), .o_data(data_m), .o_valid(valid_m),
        .i_ready(ready_m), .o_parity_err(perr_m), .o_frame_err(ferr_m), .o_overrun(ovr_m), .o_busy(busy_m));

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_a && !valid_a_q) begin
            rise_cnt_a  <= rise_cnt_a + 1;
            rise_cyc_a  <= cyc;
            rise_data_a <= data_a;
            rise_perr_a <= perr_a;
        end
        if (valid_a) vhi_cnt_a  <= vhi_cnt_a + 1;
        if (ferr_a)  ferr_cnt_a <= ferr_cnt_a + 1;
        if (ovr_a)   ovr_cnt_a  <= ovr_cnt_a + 1;
        valid_a_q <= valid_a;
    end

    always @(negedge clk) begin
        if (valid_p && !valid_p_q) begin
            rise_cnt_p  <= rise_cnt_p + 1;
            rise_data_p <= data_p;
            rise_perr_p <= perr_p;
        end
        if (valid_m && !valid_m_q) begin
            rise_cnt_m  <= rise_cnt_m + 1;
            rise_data_m <= data_m;
        end
        valid_p_q <= valid_p;
        valid_m_q <= valid_m;
    end

    task automatic drive(input int sel, input logic v);
        case (sel)
            0:       ser_a = v;
            1:       ser_p = v;
            default: ser_m = v;
        endcase
    endtask

    // Call on a falling edge; returns on the falling edge that ends the stop bit.
    task automatic send(input int sel, input logic [15:0] data, input int w, input int cpb,
                        input bit lsb, input bit pen, input bit pbit, input bit stop);
        logic [15:0] d;
        d = data;
        drive(sel, 1'b0);
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < w; i++) begin
            drive(sel, lsb ? d[i] : d[w-1-i]);
            repeat (cpb) @(negedge clk);
        end
        if (pen) begin
            drive(sel, pbit);
            repeat (cpb) @(negedge clk);
        end
        drive(sel, stop);
        repeat (cpb) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rst_valid_a got %b exp 0", valid_a); end
        checks++; if (data_a !== 7'h00) begin errors++; $display("FAIL rst_data_a got %h exp 00", data_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy_a got %b exp 0", busy_a); end
        checks++; if ({perr_a, ferr_a, ovr_a} !== 3'b000) begin errors++; $display("FAIL rst_flags_a got %b exp 000", {perr_a, ferr_a, ovr_a}); end
        checks++; if ({valid_p, valid_m} !== 2'b00) begin errors++; $display("FAIL rst_valid_pm got %b exp 00", {valid_p, valid_m}); end
        checks++; if (data_m !== 16'h0000) begin errors++; $display("FAIL rst_data_m got %h exp 0000", data_m); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_first_frame;
        int s0, r0, v0, f0, o0;
        ready_a = 1'b1;
        r0 = rise_cnt_a; v0 = vhi_cnt_a; f0 = ferr_cnt_a; o0 = ovr_cnt_a;
        s0 = cyc;
        send(0, 16'h002A, 7, 8, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        // The edge after this falling edge is the first to see the low line;
        // o_valid rises 71 edges after it, i.e. at observed cycle s0+72.
        checks++; if (rise_cyc_a - s0 !== 72) begin errors++; $display("FAIL t1_latency got %0d exp 72", rise_cyc_a - s0); end
        checks++; if (rise_data_a !== 7'h2A) begin errors++; $display("FAIL t1_data got %h exp 2a", rise_data_a); end
        checks++; if (rise_cnt_a - r0 !== 1) begin errors++; $display("FAIL t1_words got %0d exp 1", rise_cnt_a - r0); end
        checks++; if (vhi_cnt_a - v0 !== 1) begin errors++; $display("FAIL t1_valid_width got %0d exp 1", vhi_cnt_a - v0); end
        checks++; if (rise_perr_a !== 1'b0) begin errors++; $display("FAIL t1_perr got %b exp 0", rise_perr_a); end
        checks++; if ((ferr_cnt_a - f0) + (ovr_cnt_a - o0) !== 0) begin errors++; $display("FAIL t1_err_pulses got %0d exp 0", (ferr_cnt_a - f0) + (ovr_cnt_a - o0)); end
    endtask

    task automatic test_overrun;
        int o0;
        o0 = ovr_cnt_a;
        ready_a = 1'b0;
        send(0, 16'h0015, 7, 8, 1'b1, 1'b0, 1'b0, 1'b1);
        send(0, 16'h006B, 7, 8, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL t2_valid_held got %b exp 1", valid_a); end
        checks++; if (data_a !== 7'h15) begin errors++; $display("FAIL t2_data_held got %h exp 15", data_a); end
        checks++; if (ovr_cnt_a - o0 !== 1) begin errors++; $display("FAIL t2_overrun got %0d exp 1", ovr_cnt_a - o0); end
        ready_a = 1'b1;
        @(negedge clk);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL t2_handshake got %b exp 0", valid_a); end
        checks++; if (data_a !== 7'h15) begin errors++; $display("FAIL t2_data_after got %h exp 15", data_a); end
    endtask

    task automatic test_frame_error;
        int f0, r0, busy_low;
        f0 = ferr_cnt_a; r0 = rise_cnt_a; busy_low = 0;
        send(0, 16'h0033, 7, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (40) begin
            @(negedge clk);
            if (busy_a !== 1'b1) busy_low++;
        end
        checks++; if (busy_low !== 0) begin errors++; $display("FAIL t3_busy_break got %0d idle cycles exp 0", busy_low); end
        ser_a = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL t3_busy_released got %b exp 0", busy_a); end
        repeat (100) @(negedge clk);
        checks++; if (ferr_cnt_a - f0 !== 1) begin errors++; $display("FAIL t3_frame_err got %0d exp 1", ferr_cnt_a - f0); end
        checks++; if (rise_cnt_a - r0 !== 0) begin errors++; $display("FAIL t3_no_word got %0d exp 0", rise_cnt_a - r0); end
    endtask

    task automatic test_parity;
        int r0;
        ready_p = 1'b1;
        r0 = rise_cnt_p;
        send(1, 16'h0007, 7, 8, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (rise_cnt_p - r0 !== 1) begin errors++; $display("FAIL t4_words_bad got %0d exp 1", rise_cnt_p - r0); end
        checks++; if (rise_data_p !== 7'h07) begin errors++; $display("FAIL t4_data_bad got %h exp 07", rise_data_p); end
        checks++; if (rise_perr_p !== 1'b1) begin errors++; $display("FAIL t4_perr_bad got %b exp 1", rise_perr_p); end
        send(1, 16'h0007, 7, 8, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (rise_cnt_p - r0 !== 2) begin errors++; $display("FAIL t4_words_good got %0d exp 2", rise_cnt_p - r0); end
        checks++; if (rise_perr_p !== 1'b0) begin errors++; $display("FAIL t4_perr_good got %b exp 0", rise_perr_p); end
    endtask

    task automatic test_glitch_and_reset;
        int r0, f0;
        r0 = rise_cnt_a; f0 = ferr_cnt_a;
        ser_a = 1'b0;
        repeat (2) @(negedge clk);
        ser_a = 1'b1;
        repeat (120) @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL t5_glitch_busy got %b exp 0", busy_a); end
        checks++; if ((rise_cnt_a - r0) + (ferr_cnt_a - f0) !== 0) begin errors++; $display("FAIL t5_glitch_outputs got %0d exp 0", (rise_cnt_a - r0) + (ferr_cnt_a - f0)); end

        // Hold a word, then abandon a frame mid-data with reset.
        ready_a = 1'b0;
        send(0, 16'h0055, 7, 8, 1'b1, 1'b0, 1'b0, 1'b1);
        ser_a = 1'b0; repeat (8) @(negedge clk);
        ser_a = 1'b1; repeat (8) @(negedge clk);
        ser_a = 1'b0; repeat (8) @(negedge clk);
        checks++; if ({valid_a, busy_a} !== 2'b11) begin errors++; $display("FAIL t5_pre_reset got %b exp 11", {valid_a, busy_a}); end
        reset = 1'b1;
        ser_a = 1'b1;
        #1;
        checks++; if ({valid_a, busy_a} !== 2'b00) begin errors++; $display("FAIL t5_reset_ctrl got %b exp 00", {valid_a, busy_a}); end
        checks++; if (data_a !== 7'h00) begin errors++; $display("FAIL t5_reset_data got %h exp 00", data_a); end
        @(negedge clk);
        reset = 1'b0;
        ready_a = 1'b1;
        repeat (10) @(negedge clk);
        r0 = rise_cnt_a;
        send(0, 16'h007F, 7, 8, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (rise_cnt_a - r0 !== 1) begin errors++; $display("FAIL t5_words_after got %0d exp 1", rise_cnt_a - r0); end
        checks++; if (rise_data_a !== 7'h7F) begin errors++; $display("FAIL t5_data_after got %h exp 7f", rise_data_a); end
    endtask

    task automatic test_msb_first;
        int r0;
        ready_m = 1'b1;
        r0 = rise_cnt_m;
        send(2, 16'hBEEF, 16, 4, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (rise_cnt_m - r0 !== 1) begin errors++; $display("FAIL t6_words got %0d exp 1", rise_cnt_m - r0); end
        checks++; if (rise_data_m !== 16'hBEEF) begin errors++; $display("FAIL t6_data got %h exp beef", rise_data_m); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_overrun();
        test_frame_error();
        test_parity();
        test_glitch_and_reset();
        test_msb_first();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
